// File: rtl/hart_pkg.sv
// Definitions shared across the hart: data width, fetch FSM states and
// the layout of an instruction buffer entry.
package hart_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push and pop may share a cycle when non-empty,
// including when full.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word
// reads, buffers responses and handles redirects and misaligned targets.
//   state       | meaning
//   FETCH_RUN   | sequential fetch, responses buffered for decode
//   FETCH_FAULT | misaligned redirect: drain stale responses, present one fault entry
module fetch_unit
    import hart_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int              DEPTH      = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_inst_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    fetch_state_e    r_state, w_state_nxt;
    logic            r_fault_pend, w_fault_pend_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding, r_drop_cnt, w_out_next;
    logic [XLEN-1:0] r_tag_pc [DEPTH];
    logic [PW-1:0]   r_tag_wr, r_tag_rd;

    logic            w_fire, w_rsp, w_pop, w_flush;
    logic            w_fifo_push, w_fifo_empty, w_fifo_full;
    logic [CW-1:0]   w_fifo_count;
    fetch_entry_t    w_fifo_din, w_fifo_head;
    logic [CW:0]     w_used, w_limit;

    // A pop this cycle frees a slot, which keeps single-cycle memory at full rate.
    assign w_used           = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_limit          = (CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop};
    assign o_imem_req_valid = !i_rst && (r_state == FETCH_RUN) && (w_used < w_limit);
    assign o_imem_req_addr  = r_fetch_pc;
    assign w_fire           = o_imem_req_valid && i_imem_req_ready;
    assign w_rsp            = i_imem_rsp_valid && (r_outstanding != '0);
    assign w_pop            = o_inst_valid && i_inst_ready;
    assign w_out_next       = r_outstanding + CW'(w_fire) - CW'(w_rsp);

    assign o_inst_valid = !w_fifo_empty;
    assign o_inst       = o_inst_valid ? w_fifo_head.inst : '0;
    assign o_inst_pc    = o_inst_valid ? w_fifo_head.pc : '0;
    assign o_inst_fault = o_inst_valid && w_fifo_head.fault;

    always_comb begin
        w_state_nxt      = r_state;
        w_fault_pend_nxt = r_fault_pend;
        w_flush          = 1'b0;
        w_fifo_push      = 1'b0;
        w_fifo_din       = '0;
        if (i_redirect_valid) begin
            w_flush          = 1'b1;
            w_state_nxt      = (i_redirect_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_RUN;
            w_fault_pend_nxt = (i_redirect_pc[1:0] != 2'b00);
        end else if (r_state == FETCH_RUN) begin
            if (w_rsp && (r_drop_cnt == '0)) begin
                w_fifo_push = 1'b1;
                w_fifo_din  = '{inst: i_imem_rsp_data, pc: r_tag_pc[r_tag_rd], fault: 1'b0};
            end
        end else if (r_fault_pend && (r_drop_cnt == '0)) begin
            w_fifo_push      = 1'b1;
            w_fifo_din       = '{inst: '0, pc: r_fetch_pc, fault: 1'b1};
            w_fault_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= FETCH_RUN;
            r_fault_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fault_pend <= w_fault_pend_nxt;
        end
    end

    // Stale requests stay in the tag queue and retire as their responses are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_ADDR;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_fire) r_tag_wr <= r_tag_wr + 1'b1;
            if (w_rsp)  r_tag_rd <= r_tag_rd + 1'b1;
            if (i_redirect_valid) begin
                r_fetch_pc <= i_redirect_pc;
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fire) r_tag_pc[r_tag_wr] <= r_fetch_pc;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_fifo_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    a_no_push_on_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_fifo_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'h1357_9BDF;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_fault;

    int          vectors = 0;
    int          miscompares = 0;
    int          delivered = 0;
    int          d0 = 0;
    logic [31:0] exp_pc = 32'h0;
    bit          sb_on = 1'b0;
    bit          found = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    mcyc = 0;
    bit    rand_ready = 1'b0;
    int    lat_min = 1;
    int    lat_max = 1;

    fetch_unit dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .o_inst_fault     (o_inst_fault)
    );

    always #5 i_clk = ~i_clk;

    // Memory: drives ready/response just after the rising edge, captures requests mid-cycle.
    initial begin
        i_imem_req_ready = 1'b1;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        forever begin
            @(posedge i_clk);
            #1;
            mcyc++;
            i_imem_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mq[0].addr ^ K;
                void'(mq.pop_front());
            end else begin
                i_imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        mreq_t r;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                mq.delete();
            end else if (o_imem_req_valid && i_imem_req_ready) begin
                r.addr = o_imem_req_addr;
                r.due  = mcyc + int'($urandom_range(lat_min, lat_max));
                mq.push_back(r);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic scan();
        @(negedge i_clk);
        if (sb_on && o_inst_valid && i_inst_ready) begin
            check("stream_pc", o_inst_pc, exp_pc);
            check("stream_inst", o_inst, exp_pc ^ K);
            check("stream_fault", 32'(o_inst_fault), 32'd0);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            scan();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(o_imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, o_imem_req_addr, 32'h0);
        check({tag, "_inst_valid"}, 32'(o_inst_valid), 32'd0);
        check({tag, "_inst"}, o_inst, 32'h0);
        check({tag, "_inst_pc"}, o_inst_pc, 32'h0);
        check({tag, "_fault"}, 32'(o_inst_fault), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst            = 1'b1;
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");

        // Release reset: request in cycle 0, first instruction in cycle 2.
        next_cycle();
        i_rst        = 1'b0;
        i_inst_ready = 1'b1;
        sb_on        = 1'b1;
        exp_pc       = 32'h0;
        scan();
        check("c0_req_valid", 32'(o_imem_req_valid), 32'd1);
        check("c0_req_addr", o_imem_req_addr, 32'h0);
        check("c0_inst_valid", 32'(o_inst_valid), 32'd0);
        next_cycle();
        scan();
        check("c1_inst_valid", 32'(o_inst_valid), 32'd0);
        next_cycle();
        scan();
        check("c2_inst_valid", 32'(o_inst_valid), 32'd1);
        check("c2_delivered", 32'(delivered), 32'd1);
        run(6);
        check("throughput", 32'(delivered), 32'd7);

        // Decode stall: buffer fills, fetch stops, nothing lost afterwards.
        next_cycle();
        i_inst_ready = 1'b0;
        scan();
        run(9);
        check("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("stall_inst_valid", 32'(o_inst_valid), 32'd1);
        check("stall_head_pc", o_inst_pc, exp_pc);
        d0 = delivered;
        next_cycle();
        i_inst_ready = 1'b1;
        scan();
        run(7);
        check("stall_resume", 32'(delivered - d0), 32'd8);

        // Redirect while two requests are outstanding and a response lands that cycle.
        lat_min = 2;
        lat_max = 2;
        run(4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            #1;
            if (i_imem_rsp_valid && mq.size() >= 1) begin
                i_redirect_valid = 1'b1;
                i_redirect_pc    = 32'h100;
                found            = 1'b1;
            end
            scan();
        end
        check("redir_found", 32'(found), 32'd1);
        exp_pc = 32'h100;
        next_cycle();
        i_redirect_valid = 1'b0;
        scan();
        check("redir_inst_valid", 32'(o_inst_valid), 32'd0);
        check("redir_req_addr", o_imem_req_addr, 32'h100);
        d0 = delivered;
        run(16);
        check("redir_progress", 32'(delivered - d0 >= 4), 32'd1);

        // Misaligned redirect: single fault entry, no fetching until realigned.
        next_cycle();
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h102;
        scan();
        sb_on = 1'b0;
        next_cycle();
        i_redirect_valid = 1'b0;
        scan();
        check("mis_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("mis_inst_valid0", 32'(o_inst_valid), 32'd0);
        for (int i = 0; i < 10 && !o_inst_valid; i++) run(1);
        check("mis_inst_valid", 32'(o_inst_valid), 32'd1);
        check("mis_fault", 32'(o_inst_fault), 32'd1);
        check("mis_pc", o_inst_pc, 32'h102);
        check("mis_inst", o_inst, 32'h0);
        run(3);
        check("mis_hold_valid", 32'(o_inst_valid), 32'd1);
        check("mis_hold_req", 32'(o_imem_req_valid), 32'd0);
        next_cycle();
        i_inst_ready = 1'b1;
        scan();
        next_cycle();
        scan();
        check("mis_popped", 32'(o_inst_valid), 32'd0);
        check("mis_no_req", 32'(o_imem_req_valid), 32'd0);
        run(2);
        check("mis_single_entry", 32'(o_inst_valid), 32'd0);
        next_cycle();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h200;
        scan();
        next_cycle();
        i_redirect_valid = 1'b0;
        scan();
        check("realign_req_valid", 32'(o_imem_req_valid), 32'd1);
        check("realign_req_addr", o_imem_req_addr, 32'h200);
        check("realign_inst_valid", 32'(o_inst_valid), 32'd0);
        exp_pc = 32'h200;
        sb_on  = 1'b1;
        d0     = delivered;
        run(10);
        check("realign_progress", 32'(delivered - d0 >= 4), 32'd1);

        // Random memory backpressure, latency and decode stalls.
        rand_ready = 1'b1;
        lat_min    = 1;
        lat_max    = 4;
        d0         = delivered;
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            i_inst_ready = ($urandom_range(0, 1) == 1);
            scan();
        end
        check("random_progress", 32'(delivered - d0 >= 20), 32'd1);

        // PC wrap-around.
        rand_ready = 1'b0;
        lat_min    = 1;
        lat_max    = 1;
        next_cycle();
        i_inst_ready     = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'hFFFF_FFF8;
        scan();
        exp_pc = 32'hFFFF_FFF8;
        next_cycle();
        i_redirect_valid = 1'b0;
        scan();
        check("wrap_req_addr", o_imem_req_addr, 32'hFFFF_FFF8);
        d0 = delivered;
        run(10);
        check("wrap_progress", 32'(delivered - d0 >= 5), 32'd1);

        // Reset in the middle of streaming.
        next_cycle();
        i_rst = 1'b1;
        scan();
        sb_on = 1'b0;
        next_cycle();
        scan();
        check_reset_outputs("midreset");
        next_cycle();
        i_rst = 1'b0;
        scan();
        exp_pc = 32'h0;
        sb_on  = 1'b1;
        d0     = delivered;
        run(8);
        check("midreset_progress", 32'(delivered - d0 >= 5), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
